// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one single-port ROM between NREQ lookup clients.
// Optional build macro ROM_RSP_REG_EN adds a response register (2-cycle latency).
module rom_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arb_en,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      gnt,
    output logic                 rom_en,
    output logic [AW-1:0]        rom_addr,
    input  logic [DW-1:0]        rom_data,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_data,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic            found;
    int              idx;
    logic [NREQ-1:0] vld_p0;

    // Search order starts at ptr and wraps at NREQ-1, so non-power-of-2 NREQ works.
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && rst_n && arb_en && req[idx]) begin
                found = 1'b1;
                gidx  = PW'(idx);
            end
        end
        if (found) gnt[gidx] = 1'b1;
    end

    always_comb begin
        rom_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) rom_addr = req_addr[i*AW +: AW];
        end
    end

    assign rom_en = |gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
        end
    end

    // ---- stage p0: ROM address registered, response valid one cycle after grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= '0;
        end else begin
            vld_p0 <= gnt;
        end
    end

`ifdef ROM_RSP_REG_EN
    logic [NREQ-1:0] vld_p1;
    logic [DW-1:0]   data_p1;

    // ---- stage p1: ROM word captured, held between responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (|vld_p0) data_p1 <= rom_data;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_data  = data_p1;
    assign busy      = (|vld_p0) | (|vld_p1);
`else
    assign rsp_valid = vld_p0;
    assign rsp_data  = (|vld_p0) ? rom_data : '0;
    assign busy      = |vld_p0;
`endif

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Directed bench for rom_rr_arbiter with a registered-address ROM returning addr[3:0].
// Follows ROM_RSP_REG_EN to pick the expected response latency.
module tb_rom_rr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 4;
`ifdef ROM_RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                arb_en;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ-1:0]     gnt;
    logic                rom_en;
    logic [AW-1:0]       rom_addr;
    logic [DW-1:0]       rom_data;
    logic [NREQ-1:0]     rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic                busy;

    logic [AW-1:0]       rom_q = '0;

    int total = 0;
    int bad   = 0;

    // Expected grant/data history: index 1 = one cycle ago, 2 = two cycles ago
    logic [NREQ-1:0]     hv [0:2];
    logic [3:0]          hd [0:2];
    logic [3:0]          held;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_q <= rom_addr;
    end
    assign rom_data = rom_q[DW-1:0];

    rom_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en    (arb_en),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 3; i++) begin
            hv[i] = '0;
            hd[i] = '0;
        end
        held = '0;
    endtask

    // One cycle: check outputs mid-cycle, then advance and record the expected grant
    task automatic cyc(input logic [3:0] eg, input logic [4:0] ea);
        logic [3:0] ev;
        logic [3:0] ed;
        logic       eb;
        @(negedge clk);
        ev = hv[LAT];
        if (LAT == 1) ed = (hv[1] != 0) ? hd[1] : 4'h0;
        else          ed = held;
        eb = (hv[1] != 0) || (hv[LAT] != 0);
        chk("gnt",       32'(gnt),       32'(eg));
        chk("rom_en",    32'(rom_en),    32'(|eg));
        chk("rom_addr",  32'(rom_addr),  32'(ea));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("rsp_data",  32'(rsp_data),  32'(ed));
        chk("busy",      32'(busy),      32'(eb));
        @(posedge clk);
        if (LAT == 2 && hv[1] != 0) held = hd[1];
        hv[2] = hv[1];
        hd[2] = hd[1];
        hv[1] = eg;
        hd[1] = ea[3:0];
        #1;
    endtask

    initial begin
        clear_hist();
        rst_n    = 1'b0;
        arb_en   = 1'b1;
        req      = 4'hF;
        req_addr = {5'd4, 5'd3, 5'd2, 5'd1};

        // Reset holds everything quiet even with all requests up
        cyc(4'b0000, 5'd0);
        cyc(4'b0000, 5'd0);
        rst_n = 1'b1;

        // Round robin over all four, then back to requester 0
        for (int k = 0; k < 5; k++) begin
            cyc(4'(1 << (k % 4)), 5'(k % 4 + 1));
        end

        // Single request from requester 2 at address 5 (ptr ends at 3)
        req = 4'b0100;
        req_addr[14:10] = 5'd5;
        cyc(4'b0100, 5'd5);

        // Wrap from ptr=3 to 0, then skip 1 to reach 2
        req = 4'b0101;
        cyc(4'b0001, 5'd1);
        cyc(4'b0100, 5'd5);

        // Enable low blocks the grant but the pending response completes
        arb_en = 1'b0;
        req    = 4'b0010;
        cyc(4'b0000, 5'd0);
        arb_en = 1'b1;
        cyc(4'b0010, 5'd2);

        // Reset in the cycle after a grant drops the response and ptr
        req   = 4'b0000;
        rst_n = 1'b0;
        clear_hist();
        cyc(4'b0000, 5'd0);
        rst_n = 1'b1;
        req   = 4'hF;
        cyc(4'b0001, 5'd1);

        req = 4'b0000;
        cyc(4'b0000, 5'd0);
        cyc(4'b0000, 5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
